// File: rtl/cmd_pkg.sv
// Shared command-protocol definitions for the responder and the stimulus generator.
// Holds the command encoding, the widths and the mapping from a command to its latency class.
package cmd_pkg;

  localparam int CMD_W      = 3;
  localparam int DW_DEFAULT = 64;
  localparam int CNT_W      = 3;

  typedef enum logic [CMD_W-1:0] {
    RST  = 3'd0,
    INIT = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    MULT = 3'd4,
    DIV  = 3'd5,
    REM  = 3'd6,
    HLT  = 3'd7
  } cmd_type_t;

  typedef enum logic [1:0] {
    LC_NONE,
    LC_ALU,
    LC_MUL,
    LC_DIV
  } lat_class_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } resp_state_t;

  function automatic lat_class_t lat_class(input cmd_type_t c);
    case (c)
      INIT, ADD, SUB: return LC_ALU;
      MULT:           return LC_MUL;
      DIV, REM:       return LC_DIV;
      default:        return LC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_responder_if.sv
// Command vld/rdy channel plus the completion (done) bus between generator and responder.
interface cmd_responder_if
  import cmd_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 4
);
  localparam int TW = $clog2(DEPTH);

  logic             vld_i;
  logic             rdy_o;
  logic [CMD_W-1:0] cmd_i;
  logic [DW-1:0]    opd1_i;
  logic [DW-1:0]    opd2_i;
  logic             done_o;
  logic [CMD_W-1:0] done_cmd_o;
  logic [TW-1:0]    done_tag_o;
  logic [DW-1:0]    done_result_o;
  logic             done_dz_o;

  modport master (
    output vld_i, cmd_i, opd1_i, opd2_i,
    input  rdy_o, done_o, done_cmd_o, done_tag_o, done_result_o, done_dz_o
  );

  modport slave (
    input  vld_i, cmd_i, opd1_i, opd2_i,
    output rdy_o, done_o, done_cmd_o, done_tag_o, done_result_o, done_dz_o
  );
endinterface

// File: rtl/cmd_exec_alu.sv
// Combinational command executor: result and divide-by-zero flag from (cmd, opd1, opd2), mod 2^DW.
module cmd_exec_alu
  import cmd_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  cmd_type_t     cmd_i,
  input  logic [DW-1:0] opd1_i,
  input  logic [DW-1:0] opd2_i,
  output logic [DW-1:0] result_o,
  output logic          dz_o
);

  always_comb begin
    result_o = '0;
    dz_o     = 1'b0;
    case (cmd_i)
      INIT: result_o = opd1_i;
      ADD:  result_o = opd1_i + opd2_i;
      SUB:  result_o = opd1_i - opd2_i;
      MULT: result_o = opd1_i * opd2_i;
      DIV: begin
        if (opd2_i == '0) begin
          result_o = '1;
          dz_o     = 1'b1;
        end else begin
          result_o = opd1_i / opd2_i;
        end
      end
      REM: begin
        if (opd2_i == '0) begin
          result_o = opd1_i;
          dz_o     = 1'b1;
        end else begin
          result_o = opd1_i % opd2_i;
        end
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/cmd_responder.sv
// Command target: accepts commands into an outstanding-slot table, retires each after its
// class latency on a registered done bus, in issue order or lowest-slot-first.
module cmd_responder
  import cmd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int LAT_ALU = 2,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 7,
  localparam int TW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  cmd_responder_if.slave    bus,
  input  logic              ooo_en_i,
  output logic [TW:0]       outstanding_o,
  output logic              halted_o,
  output logic              hlt_err_o
);

  localparam logic [TW:0] DEPTH_C = (TW+1)'(DEPTH);

  resp_state_t      st_q, st_d;
  logic [DEPTH-1:0] vld_q, vld_d, elig, dz_q;
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  cmd_type_t        scmd_q [DEPTH];
  logic [DW-1:0]    res_q [DEPTH];
  logic [TW-1:0]    ord_q [DEPTH];
  logic [TW-1:0]    ord_d [DEPTH];
  logic [TW:0]      out_q, out_d, push_pos;
  logic             ooo_q, hlt_err_q;
  logic             rdy, acc, acc_rst, acc_hlt, acc_slot, cmp, found;
  logic [TW-1:0]    free_idx, cmp_idx;
  logic [CNT_W-1:0] lat_m1;
  cmd_type_t        cmd_in;
  logic [DW-1:0]    alu_res;
  logic             alu_dz;
  logic             done_d, done_q, dz_d, ddz_q;
  cmd_type_t        dcmd_d, dcmd_q;
  logic [TW-1:0]    dtag_d, dtag_q;
  logic [DW-1:0]    dres_d, dres_q;

  assign cmd_in   = cmd_type_t'(bus.cmd_i);
  assign rdy      = ~rst & (st_q == ST_RUN) & (out_q < DEPTH_C);
  assign acc      = bus.vld_i & rdy;
  assign acc_rst  = acc & (cmd_in == RST);
  assign acc_hlt  = acc & (cmd_in == HLT);
  assign acc_slot = acc & ~acc_rst & ~acc_hlt;

  cmd_exec_alu #(.DW(DW)) u_alu (
    .cmd_i    (cmd_in),
    .opd1_i   (bus.opd1_i),
    .opd2_i   (bus.opd2_i),
    .result_o (alu_res),
    .dz_o     (alu_dz)
  );

  // Countdown holds latency-1 so the slot is selectable exactly L edges after accept
  always_comb begin
    case (lat_class(cmd_in))
      LC_MUL:  lat_m1 = CNT_W'(LAT_MUL - 1);
      LC_DIV:  lat_m1 = CNT_W'(LAT_DIV - 1);
      default: lat_m1 = CNT_W'(LAT_ALU - 1);
    endcase
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) elig[i] = vld_q[i] & (cnt_q[i] == '0);
  end

  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    cmp      = 1'b0;
    cmp_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld_q[i] && !found) begin
        free_idx = TW'(i);
        found    = 1'b1;
      end
    end
    if (!acc_rst) begin
      if (ooo_q) begin
        for (int i = DEPTH-1; i >= 0; i--) begin
          if (elig[i]) begin
            cmp     = 1'b1;
            cmp_idx = TW'(i);
          end
        end
      end else if (out_q != '0 && elig[ord_q[0]]) begin
        cmp     = 1'b1;
        cmp_idx = ord_q[0];
      end
    end
  end

  // Order queue pops its head on every completion; it is only consulted in in-order mode,
  // and the mode can change only when the table is empty, so its contents never go stale.
  always_comb begin
    vld_d    = vld_q;
    out_d    = out_q;
    push_pos = out_q - (TW+1)'(cmp);
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = (vld_q[i] && cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
      ord_d[i] = (cmp && i < DEPTH-1) ? ord_q[(i+1) % DEPTH] : ord_q[i];
    end
    if (acc_rst) begin
      vld_d = '0;
      out_d = '0;
    end else begin
      if (cmp) vld_d[cmp_idx] = 1'b0;
      if (acc_slot) begin
        vld_d[free_idx] = 1'b1;
        cnt_d[free_idx] = lat_m1;
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (acc_slot && (TW+1)'(j) == push_pos) ord_d[j] = free_idx;
      end
      out_d = out_q + (TW+1)'(acc_slot) - (TW+1)'(cmp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_RUN;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_RUN:   if (acc_hlt) st_d = (out_q == '0) ? ST_HALTED : ST_DRAIN;
      ST_DRAIN: if (out_q == '0) st_d = ST_HALTED;
      default:  st_d = st_q;
    endcase
  end

  always_comb begin
    done_d = 1'b0;
    dcmd_d = RST;
    dtag_d = '0;
    dres_d = '0;
    dz_d   = 1'b0;
    if (acc_rst) begin
      done_d = 1'b1;
    end else if ((acc_hlt && out_q == '0) || (st_q == ST_DRAIN && out_q == '0)) begin
      done_d = 1'b1;
      dcmd_d = HLT;
    end else if (cmp) begin
      done_d = 1'b1;
      dcmd_d = scmd_q[cmp_idx];
      dtag_d = cmp_idx;
      dres_d = res_q[cmp_idx];
      dz_d   = dz_q[cmp_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      out_q     <= '0;
      ooo_q     <= 1'b0;
      hlt_err_q <= 1'b0;
      done_q    <= 1'b0;
      dcmd_q    <= RST;
      dtag_q    <= '0;
      dres_q    <= '0;
      ddz_q     <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      out_q  <= out_d;
      done_q <= done_d;
      dcmd_q <= dcmd_d;
      dtag_q <= dtag_d;
      dres_q <= dres_d;
      ddz_q  <= dz_d;
      if (out_q == '0 && st_q == ST_RUN) ooo_q <= ooo_en_i;
      if (acc_hlt && out_q != '0) hlt_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      cnt_q[i] <= cnt_d[i];
      ord_q[i] <= ord_d[i];
    end
    if (acc_slot) begin
      scmd_q[free_idx] <= cmd_in;
      res_q[free_idx]  <= alu_res;
      dz_q[free_idx]   <= alu_dz;
    end
  end

  assign bus.rdy_o         = rdy;
  assign bus.done_o        = done_q;
  assign bus.done_cmd_o    = dcmd_q;
  assign bus.done_tag_o    = dtag_q;
  assign bus.done_result_o = dres_q;
  assign bus.done_dz_o     = ddz_q;
  assign outstanding_o     = out_q;
  assign halted_o          = (st_q == ST_HALTED);
  assign hlt_err_o         = hlt_err_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Scoreboard bench for cmd_responder: a queue-based reference model predicts each completion
// and its cycle; a negedge monitor pops and compares whenever the done bus fires.
module tb_cmd_responder;
  import cmd_pkg::*;

  localparam int DEPTH = 4, DW = 64, LAT_ALU = 2, LAT_MUL = 4, LAT_DIV = 7;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ooo_en = 1'b0;
  logic [2:0] outstanding;
  logic       halted, hlt_err;
  int         checks = 0;
  int         failures = 0;

  cmd_responder_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  cmd_responder #(
    .DEPTH(DEPTH), .DW(DW), .LAT_ALU(LAT_ALU), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .ooo_en_i      (ooo_en),
    .outstanding_o (outstanding),
    .halted_o      (halted),
    .hlt_err_o     (hlt_err)
  );

  always #5 clk = ~clk;

  typedef struct { cmd_type_t c; int tag; logic [63:0] res; bit dz; int due; } ent_t;
  typedef struct { cmd_type_t c; int tag; logic [63:0] res; bit dz; } dn_t;

  ent_t ents[$];
  dn_t  expq[$];
  int   m_st = M_RUN;
  bit   m_ooo = 1'b0, m_herr = 1'b0, started = 1'b0;
  int   cyc = 0;

  function automatic int latency(input cmd_type_t c);
    if (c == MULT) return LAT_MUL;
    if (c == DIV || c == REM) return LAT_DIV;
    return LAT_ALU;
  endfunction

  function automatic void ref_op(input cmd_type_t c, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output bit dz);
    dz = 1'b0;
    case (c)
      INIT: r = a;
      ADD:  r = a + b;
      SUB:  r = a - b;
      MULT: r = a * b;
      DIV:  if (b == 64'd0) begin r = '1; dz = 1'b1; end else r = a / b;
      REM:  if (b == 64'd0) begin r = a;  dz = 1'b1; end else r = a % b;
      default: r = 64'd0;
    endcase
  endfunction

  function automatic bit tag_used(input int t);
    foreach (ents[k]) if (ents[k].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: advances once per clock edge from the bench's own view of the inputs
  initial begin : model_p
    int pre_n, pre_st, idx, ft;
    bit acc;
    cmd_type_t c;
    logic [63:0] r;
    bit dz;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        ents.delete(); expq.delete();
        m_st = M_RUN; m_ooo = 1'b0; m_herr = 1'b0; started = 1'b1;
      end else if (started) begin
        pre_n  = ents.size();
        pre_st = m_st;
        c      = cmd_type_t'(bus.cmd_i);
        acc    = bus.vld_i && m_st == M_RUN && pre_n < DEPTH;
        if (acc && c == RST) begin
          ents.delete();
          expq.push_back('{RST, 0, 64'd0, 1'b0});
        end else begin
          idx = -1;
          if (m_ooo) begin
            foreach (ents[k])
              if (ents[k].due <= cyc && (idx < 0 || ents[k].tag < ents[idx].tag)) idx = k;
          end else if (pre_n > 0 && ents[0].due <= cyc) begin
            idx = 0;
          end
          ft = 0;
          while (tag_used(ft)) ft++;
          if (acc && c == HLT) begin
            if (pre_n == 0) begin
              m_st = M_HALT;
              expq.push_back('{HLT, 0, 64'd0, 1'b0});
            end else begin
              m_st = M_DRAIN;
              m_herr = 1'b1;
            end
          end else if (m_st == M_DRAIN && pre_n == 0) begin
            m_st = M_HALT;
            expq.push_back('{HLT, 0, 64'd0, 1'b0});
          end
          if (idx >= 0) begin
            expq.push_back('{ents[idx].c, ents[idx].tag, ents[idx].res, ents[idx].dz});
            ents.delete(idx);
          end
          if (acc && c != HLT) begin
            ref_op(c, bus.opd1_i, bus.opd2_i, r, dz);
            ents.push_back('{c, ft, r, dz, cyc + latency(c)});
          end
        end
        if (pre_n == 0 && pre_st == M_RUN) m_ooo = ooo_en;
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each done pulse
  initial begin : monitor_p
    dn_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        check("rdy_o", 64'(bus.rdy_o), 64'(!rst && m_st == M_RUN && ents.size() < DEPTH));
        check("outstanding_o", 64'(outstanding), 64'(ents.size()));
        check("halted_o", 64'(halted), 64'(m_st == M_HALT));
        check("hlt_err_o", 64'(hlt_err), 64'(m_herr));
        check("done_o", 64'(bus.done_o), 64'(expq.size() != 0));
        if (bus.done_o && expq.size() != 0) begin
          e = expq.pop_front();
          check("done_cmd_o", 64'(bus.done_cmd_o), 64'(e.c));
          check("done_tag_o", 64'(bus.done_tag_o), 64'(e.tag));
          check("done_result_o", bus.done_result_o, e.res);
          check("done_dz_o", 64'(bus.done_dz_o), 64'(e.dz));
        end else begin
          expq.delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input cmd_type_t c, input logic [63:0] a, input logic [63:0] b);
    int n;
    n = 0;
    bus.vld_i = 1'b1; bus.cmd_i = c; bus.opd1_i = a; bus.opd2_i = b;
    while (!bus.rdy_o && n < 100) begin
      step();
      n++;
    end
    if (!bus.rdy_o) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: cmd %0d not accepted after %0d cycles", c, n);
    end else begin
      step();
    end
    bus.vld_i = 1'b0;
  endtask

  task automatic hold(input cmd_type_t c, input int n);
    bus.vld_i = 1'b1; bus.cmd_i = c; bus.opd1_i = 64'd1; bus.opd2_i = 64'd1;
    idle(n);
    bus.vld_i = 1'b0;
  endtask

  function automatic logic [63:0] rnd_opd();
    case ($urandom_range(0, 3))
      0:       return 64'($urandom_range(0, 20));
      1:       return {$urandom, $urandom};
      2:       return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5));
      default: return {32'd0, $urandom};
    endcase
  endfunction

  initial begin : watchdog_p
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim_p
    cmd_type_t c;
    logic [63:0] a, b;
    int r;
    bus.vld_i = 1'b0; bus.cmd_i = RST; bus.opd1_i = '0; bus.opd2_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(ADD, 64'd5, 64'd3);
    idle(4);
    issue(DIV, 64'd10, 64'd0);
    issue(REM, 64'd10, 64'd0);
    idle(10);
    issue(DIV, 64'd9, 64'd2);
    issue(ADD, 64'd1, 64'd1);
    idle(10);
    ooo_en = 1'b1;
    idle(1);
    issue(DIV, 64'd9, 64'd2);
    issue(ADD, 64'd1, 64'd1);
    idle(10);
    ooo_en = 1'b0;
    idle(1);
    repeat (5) issue(MULT, rnd_opd(), rnd_opd());
    idle(10);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end else if (r < 5) begin
        issue(RST, rnd_opd(), rnd_opd());
      end else if (r < 12) begin
        ooo_en = 1'($urandom_range(0, 1));
      end else begin
        c = cmd_type_t'($urandom_range(1, 6));
        a = rnd_opd();
        b = ((c == DIV || c == REM) && $urandom_range(0, 2) == 0) ? 64'd0 : rnd_opd();
        issue(c, a, b);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    idle(10);

    issue(SUB, 64'd7, 64'd2);
    issue(HLT, 64'd0, 64'd0);
    idle(5);
    hold(ADD, 6);
    idle(2);

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    issue(DIV, 64'd100, 64'd7);
    issue(DIV, 64'd5, 64'd5);
    issue(RST, 64'd0, 64'd0);
    idle(10);

    issue(HLT, 64'd0, 64'd0);
    idle(3);
    hold(INIT, 3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
